// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM state encoding
// and the data word returned when a memory transaction is abandoned.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_I = 3'd1,
        WAIT_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arbState_t;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Counts memory wait cycles; expired marks the last cycle the arbiter will
// wait for m_ack before abandoning the transaction.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and data
// ports; data wins collisions until MAX_D_BURST grants starve a pending fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 16,
    parameter int MAX_D_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          freeze,
    output logic          err
);

    localparam int BW = $clog2(MAX_D_BURST + 1);

    arbState_t     stateQ, stateD;
    logic [BW-1:0] burstCnt;
    logic          isIdle, inWait, grantD, grantI, ackDone, tmoDone, tmoExpired;

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) uTimeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (grantD | grantI),
        .enable  (inWait & ~m_ack),
        .expired (tmoExpired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: begin
                if (grantD)      stateD = WAIT_D;
                else if (grantI) stateD = WAIT_I;
            end
            WAIT_I:  if (m_ack || tmoExpired) stateD = RESP_I;
            WAIT_D:  if (m_ack || tmoExpired) stateD = RESP_D;
            RESP_I:  stateD = IDLE;
            RESP_D:  stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // A pending fetch overrides data only once the burst allowance is used up.
    always_comb begin
        isIdle  = (stateQ == IDLE);
        inWait  = (stateQ == WAIT_I) || (stateQ == WAIT_D);
        grantD  = isIdle && d_req && !(if_req && (burstCnt == BW'(MAX_D_BURST)));
        grantI  = isIdle && if_req && !grantD;
        ackDone = inWait && m_ack;
        tmoDone = inWait && !m_ack && tmoExpired;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            if_ready <= 1'b0;
            d_rdata  <= '0;
            d_ready  <= 1'b0;
            err      <= 1'b0;
            burstCnt <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            if (grantD) begin
                m_req   <= 1'b1;
                m_addr  <= d_addr;
                m_we    <= d_we;
                m_wdata <= d_wdata;
            end else if (grantI) begin
                m_req  <= 1'b1;
                m_addr <= if_addr;
                m_we   <= 1'b0;
            end

            if (ackDone) begin
                m_req <= 1'b0;
                m_we  <= 1'b0;
                if (stateQ == WAIT_I) begin
                    if_rdata <= m_rdata;
                    if_ready <= 1'b1;
                end else begin
                    if (!m_we) d_rdata <= m_rdata;
                    d_ready <= 1'b1;
                end
            end else if (tmoDone) begin
                m_req <= 1'b0;
                err   <= 1'b1;
                if (stateQ == WAIT_I) begin
                    if_rdata <= DW'(ERR_DATA);
                    if_ready <= 1'b1;
                end else begin
                    d_rdata <= DW'(ERR_DATA);
                    d_ready <= 1'b1;
                end
            end

            if (grantI || (isIdle && !if_req)) begin
                burstCnt <= '0;
            end else if (grantD && (burstCnt != BW'(MAX_D_BURST))) begin
                burstCnt <= burstCnt + BW'(1);
            end
        end
    end

    assign freeze = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule
